// File: rtl/cam_cpi_tx.sv
// cam_cpi_tx - camera-side CPI transmitter for emulation and directed tests.
//
// This block stands in for a real camera sensor. It generates CPI frames with
// pclk, vsync, hsync and an 8-bit data bus. The frames carry a ramp, constant
// or checkerboard test pattern.
//
// Frame layout (all states are whole line periods of LINE_BYTES+H_BLANK pclk):
//   VSYNC (VS_LINES) -> VBP (VBP_LINES) -> ACTIVE (LINES) -> VFP (VFP_LINES)
// A state whose line count is 0 is skipped.
//
// Handshake: start_i is a one-cycle strobe accepted only in IDLE (busy_o=0).
// stop_i is a one-cycle strobe honoured only while busy. The frame in flight
// always completes before the block returns to IDLE.
//
// Ports:
//   clk_i, rst_i     system clock, asynchronous active-high reset
//   start_i          start strobe (ignored while busy_o=1)
//   stop_i           finish the current frame, then go idle
//   frame_num_i      frames per start, 0 = continuous (sampled on start)
//   pattern_i        0=ramp, 1=constant, 2=checker, 3=constant (sampled on start)
//   const_i          constant-pattern byte (sampled on start)
//   cam_pclk_o       pixel clock (low half first in every period)
//   cam_vsync_o      frame sync, active-high
//   cam_hsync_o      line valid, active-high
//   cam_data_o       pixel byte
//   busy_o           high while a frame sequence is running
//   frame_done_o     one-cycle pulse on the last clk of each frame
//   frame_cnt_o      frames completed since the last start (wraps)
module cam_cpi_tx #(
    parameter int PCLK_HALF  = 2,
    parameter int LINE_BYTES = 640,
    parameter int LINES      = 240,
    parameter int H_BLANK    = 16,
    parameter int VS_LINES   = 2,
    parameter int VBP_LINES  = 4,
    parameter int VFP_LINES  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [7:0] frame_num_i,
    input  logic [1:0] pattern_i,
    input  logic [7:0] const_i,
    output logic       cam_pclk_o,
    output logic       cam_vsync_o,
    output logic       cam_hsync_o,
    output logic [7:0] cam_data_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic [7:0] frame_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    localparam int PERIOD_CLKS  = 2 * PCLK_HALF;
    localparam int LINE_PERIODS = LINE_BYTES + H_BLANK;
    localparam int PW           = $clog2(PERIOD_CLKS + 1);
    localparam int BW           = $clog2(LINE_PERIODS + 1);

    localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD_CLKS - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(PCLK_HALF);
    localparam logic [BW-1:0] BYTE_LAST  = BW'(LINE_PERIODS - 1);
    localparam logic [BW-1:0] BYTE_ACT   = BW'(LINE_BYTES);

    state_t        state, state_next;
    logic [PW-1:0] phase;
    logic [BW-1:0] byte_cnt;
    logic [15:0]   line_cnt;
    logic [7:0]    frame_cnt;
    logic [7:0]    frame_num_q;
    logic [1:0]    pattern_q;
    logic [7:0]    const_q;
    logic          stop_flag;

    logic          period_end;
    logic          line_end;
    logic          state_end;
    logic          frame_done;
    logic          count_hit;
    logic          stop_req;
    logic [15:0]   b16;
    logic [7:0]    pix;

    // Next frame-layout state after s, skipping states with zero lines.
    // S_IDLE as the result means "no more states in this frame"; as the
    // argument it asks for the first state of a frame. Later tests
    // override earlier ones, so the nearest non-empty state wins.
    function automatic state_t after_state(input state_t s);
        state_t r;
        r = S_IDLE;
        if ((s == S_IDLE || s == S_VSYNC || s == S_VBP || s == S_ACTIVE) && VFP_LINES > 0)
            r = S_VFP;
        if ((s == S_IDLE || s == S_VSYNC || s == S_VBP) && LINES > 0)
            r = S_ACTIVE;
        if ((s == S_IDLE || s == S_VSYNC) && VBP_LINES > 0)
            r = S_VBP;
        if (s == S_IDLE && VS_LINES > 0)
            r = S_VSYNC;
        return r;
    endfunction

    function automatic logic [15:0] last_line(input state_t s);
        logic [15:0] r;
        case (s)
            S_VSYNC:  r = 16'(VS_LINES - 1);
            S_VBP:    r = 16'(VBP_LINES - 1);
            S_ACTIVE: r = 16'(LINES - 1);
            S_VFP:    r = 16'(VFP_LINES - 1);
            default:  r = 16'd0;
        endcase
        return r;
    endfunction

    // A stop strobe in the frame's final cycle still counts for this frame.
    assign stop_req  = stop_flag | stop_i;
    assign count_hit = (frame_num_q != 8'd0) && ((frame_cnt + 8'd1) == frame_num_q);

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        period_end = (phase == PHASE_LAST);
        line_end   = period_end && (byte_cnt == BYTE_LAST);
        state_end  = line_end && (line_cnt == last_line(state));
        case (state)
            S_IDLE: begin
                if (start_i)
                    state_next = after_state(S_IDLE);
            end
            default: begin
                if (state_end) begin
                    if (after_state(state) == S_IDLE) begin
                        frame_done = 1'b1;
                        state_next = (stop_req || count_hit) ? S_IDLE : after_state(S_IDLE);
                    end else begin
                        state_next = after_state(state);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            phase       <= '0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
            frame_num_q <= '0;
            pattern_q   <= '0;
            const_q     <= '0;
            stop_flag   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                phase    <= '0;
                byte_cnt <= '0;
                line_cnt <= '0;
                if (start_i) begin
                    frame_num_q <= frame_num_i;
                    pattern_q   <= pattern_i;
                    const_q     <= const_i;
                    frame_cnt   <= '0;
                    // A stop in the same cycle as start is dropped.
                    stop_flag   <= 1'b0;
                end
            end else begin
                if (stop_i)
                    stop_flag <= 1'b1;
                if (frame_done)
                    frame_cnt <= frame_cnt + 8'd1;
                phase <= period_end ? '0 : phase + PW'(1);
                if (period_end)
                    byte_cnt <= line_end ? '0 : byte_cnt + BW'(1);
                if (line_end)
                    line_cnt <= state_end ? 16'd0 : line_cnt + 16'd1;
            end
        end
    end

    // Byte/line/frame counters only move at period boundaries. As a result
    // every output below changes on the cycle pclk goes low.
    assign b16 = 16'(byte_cnt);

    always_comb begin
        pix = const_q;
        case (pattern_q)
            2'd0:    pix = b16[7:0] + line_cnt[7:0] + frame_cnt;
            2'd2:    pix = (b16[3] ^ line_cnt[3]) ? 8'hFF : 8'h00;
            default: pix = const_q;
        endcase
    end

    assign busy_o       = (state != S_IDLE);
    assign cam_pclk_o   = busy_o && (phase >= PHASE_HIGH);
    assign cam_vsync_o  = (state == S_VSYNC);
    assign cam_hsync_o  = (state == S_ACTIVE) && (byte_cnt < BYTE_ACT);
    assign cam_data_o   = cam_hsync_o ? pix : 8'h00;
    assign frame_done_o = frame_done;
    assign frame_cnt_o  = frame_cnt;

endmodule

// File: doc/cam_cpi_tx.md
Name: cam_cpi_tx

Overview:
- Camera-side CPI transmitter: synthesizes pclk/vsync/hsync/data[7:0] frames to drive the SoC camera pads during FPGA emulation and directed tests, with no physical sensor.
- Sits in the emulation top beside the SoC instance. Configured by static parameters; driven by simple start/stop strobes.
- Generates ramp, constant or checkerboard test patterns.

Parameters:
- PCLK_HALF, 2, clk_i cycles per pclk half-period (>=1).
- LINE_BYTES, 640, active bytes per line (320 px RGB565).
- LINES, 240, active lines per frame.
- H_BLANK, 16, pclk periods of hsync low after each line's active bytes (>=1).
- VS_LINES, 2, line periods with vsync high.
- VBP_LINES, 4, blank line periods after vsync.
- VFP_LINES, 4, blank line periods after the last active line.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle start strobe; ignored while busy_o=1
- stop_i  in  1  one-cycle strobe; finish the current frame, then go idle
- frame_num_i  in  8  frames to send per start; 0 = continuous; sampled on start
- pattern_i  in  2  0=ramp, 1=constant, 2=checkerboard, 3=reserved (treated as constant); sampled on start
- const_i  in  8  byte used by the constant pattern; sampled on start
- cam_pclk_o  out  1  pixel clock
- cam_vsync_o  out  1  frame sync, active-high
- cam_hsync_o  out  1  line valid, active-high
- cam_data_o  out  8  pixel byte
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE
- frame_done_o  out  1  one-cycle pulse at the end of each frame's VFP
- frame_cnt_o  out  8  frames completed since the last start; wraps at 255

Behaviour:
- Reset: state=IDLE. All outputs 0. All counters 0.
- Pclk generation:
  - A phase counter runs only while busy.
  - cam_pclk_o is low for PCLK_HALF cycles, then high for PCLK_HALF cycles (one "period").
  - vsync, hsync and data change only on the cycle pclk goes low, i.e. at period start. The receiver samples them on the pclk rising edge.
- Start: when start_i=1 in IDLE at cycle N, mode/const/frame_num are latched and frame_cnt_o is cleared. State becomes VSYNC at N+1, with cam_vsync_o=1 and pclk low from N+1.
- Line period: LINE_BYTES+H_BLANK pclk periods in every state.
- State machine:
  - VSYNC: VS_LINES line periods, vsync=1, hsync=0, data=0.
  - VBP: VBP_LINES line periods, all low.
  - ACTIVE: LINES line periods. hsync=1 with data valid for the first LINE_BYTES periods, then hsync=0 and data=0 for H_BLANK periods.
  - VFP: VFP_LINES line periods, all low.
  - End of VFP (last clk of the last period): frame_done_o pulses and frame_cnt_o increments. Next state is IDLE if the stop flag is set or frame_cnt reaches frame_num_i (nonzero); otherwise VSYNC.
- Zero-count states: any *_LINES parameter equal to 0 skips that state.
- Data, with b = byte index in line (0..LINE_BYTES-1), l = active line index, f = frame_cnt (8-bit):
  - Ramp: (b+l+f) mod 256.
  - Constant: const_i.
  - Checker: 0xFF if ((b>>3)^(l>>3)) bit0 = 1, else 0x00.
- Stop:
  - stop_i sets a sticky flag while busy; the current frame always completes.
  - stop_i in IDLE has no effect.
  - stop_i and start_i in the same IDLE cycle: start wins, stop is dropped.
- Return to IDLE: on the cycle after frame_done, pclk and all sync/data outputs are 0 and busy_o=0. frame_cnt_o holds its value.
- Reset mid-frame: asynchronous return to the reset state. No partial frame_done pulse is generated.

Test Plan (bench params: PCLK_HALF=1, LINE_BYTES=4, LINES=2, H_BLANK=2, VS_LINES=1, VBP_LINES=1, VFP_LINES=1; line = 6 pclk = 12 clk, frame = 5 lines = 60 clk):
1. Start ramp, frame_num=1:
   - vsync high for clk 1..12 after start.
   - hsync high for 4 pclk in line 2 with bytes 00,01,02,03.
   - Line 3 bytes 01,02,03,04.
   - frame_done at clk 60; busy_o=0 at 61; frame_cnt_o=1.
2. Ramp, frame_num=2: frame 2 line 0 bytes 01,02,03,04; two frame_done pulses 60 clk apart; frame_cnt_o=2.
3. frame_num=0 continuous, stop_i pulsed mid-ACTIVE of frame 3:
   - Frame 3 completes; frame_cnt_o=3; IDLE afterwards.
   - No vsync after that frame's VFP.
4. Pattern=1, const_i=0xA5: every hsync-high byte is 0xA5; data=0 whenever hsync=0.
5. Pattern=2, LINE_BYTES=16, LINES=16:
   - Line 0 bytes 0-7 are 00 and bytes 8-15 are FF.
   - Line 8 is inverted.
6. Boundary and reset cases:
   - start_i while busy is ignored (frame count and timing unchanged).
   - rst_i asserted mid-VBP: all outputs 0 asynchronously; no frame_done.
   - After release, a new start behaves as scenario 1.
